cube_edge_sequencer: RTL and testbench
======================================

Name: cube_edge_sequencer

Overview:
Upstream feeder for the LineCUBE line drawer. It holds the 8 projected screen-space vertices of a wireframe cube and walks a fixed 12-edge table on each `go`. For every edge it presents x0/y0/x1/y1 with a start/done handshake to the drawer, then pulses `frame_done` once the last edge completes.

Parameters:
- X_W, 11, x coordinate width (matches drawer x0/x1).
- Y_W, 10, y coordinate width (matches drawer y0/y1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- vert_we  in  1  vertex write strobe.
- vert_addr  in  3  vertex index 0..7; bit0 = x-side, bit1 = y-side, bit2 = z-side of cube.
- vert_x  in  X_W  vertex x written.
- vert_y  in  Y_W  vertex y written.
- go  in  1  start one frame (level sampled in IDLE only).
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after edge 11 is released.
- edge_idx  out  4  current edge 0..11.
- line_start  out  1  to drawer start.
- line_x0, line_x1  out  X_W  to drawer x0/x1.
- line_y0, line_y1  out  Y_W  to drawer y0/y1.
- line_done  in  1  from drawer done.

Behaviour:
- Clocking and reset: one clock `clk`. `reset` is synchronous, active-high. All outputs and all vertex registers are 0 on reset, and state returns to IDLE.
- Reset mid-frame: `line_start` drops on the next edge. No `frame_done` is issued.
- Vertex writes: a write takes effect on the clock edge where `vert_we` = 1 and `busy` = 0. Writes while `busy` = 1 are ignored, so the frame uses a frozen vertex set.
- Edge table: entries 0..11 are (0,1) (2,3) (4,5) (6,7) (0,2) (1,3) (4,6) (5,7) (0,4) (1,5) (2,6) (3,7). The first index drives x0/y0 and the second drives x1/y1.
- FSM states: IDLE, LOAD, WAIT, RELEASE.
- IDLE:
  - `busy` = 0.
  - `go` = 1 → `edge_idx` <= 0, `busy` <= 1, go to LOAD.
- LOAD (1 cycle):
  - register endpoints from the table for `edge_idx`.
  - `line_start` <= 1, go to WAIT.
  - `line_start` therefore rises 2 cycles after `go` is sampled.
- WAIT:
  - hold `line_start` = 1; endpoints stay stable.
  - `line_done` = 1 → `line_start` <= 0, go to RELEASE.
- RELEASE:
  - `line_start` = 0; wait for `line_done` = 0, so a sticky `done` is not double-counted.
  - then, if `edge_idx` = 11: `busy` <= 0, `frame_done` <= 1 for one cycle, go to IDLE.
  - otherwise: `edge_idx` += 1, go to LOAD.
- Timing: minimum per edge = 3 cycles plus drawer latency. `line_start` is low for at least 1 cycle between edges.
- `go` while `busy` = 1 is ignored.
- `go` held high in the `frame_done` cycle: accepted on the following IDLE cycle, so back-to-back frames work.
- Endpoints are passed unmodified, with no arithmetic, clipping or ordering. Drawer handles any direction.

Optional Feature:
- Macro: `CUBE_SKIP_DEGENERATE_EN`.
- With the macro, in LOAD: if x0 == x1 and y0 == y1, `line_start` is not asserted and the FSM goes straight to the RELEASE decision, costing 1 cycle per skipped edge.
- Without the macro, every edge is issued to the drawer, including zero-length ones.

Decomposition:
- Package `cube_pkg`:
  - X_W/Y_W constants.
  - N_VERT = 8, N_EDGE = 12.
  - FSM state enum.
  - constant 12-entry edge table of 3-bit index pairs.
- Sub-module `cube_vertex_regs`: 8×(X_W+Y_W) register file with a gated write port and two combinational read ports.

Test Plan:
- Basic frame:
  - Stimulus: write vertex i with x = 100 + 200·b0 + 60·b2 and y = 50 + 200·b1 + 40·b2. Stub drawer raises `done` 5 cycles after `start` and drops it 1 cycle after `start` falls. Pulse `go`.
  - Response: 12 `line_start` assertions; edge 0 = (100,50)→(300,50); edge 4 = (100,50)→(100,250); edge 11 = (300,250)→(360,290); exactly one `frame_done`; `busy` low afterwards.
- Ignored inputs during a frame:
  - Stimulus: `go` and vertex writes during the frame; overwrite vertex 7 with (0,0) at edge 3.
  - Response: still exactly 12 edges; edge 11 ends at (360,290); vertex 7 unchanged.
- Sticky done:
  - Stimulus: stub holds `done` high 20 cycles after `start` falls.
  - Response: `edge_idx` does not advance and `line_start` stays low until `done` drops.
- Reset mid-frame:
  - Stimulus: assert `reset` during WAIT of edge 6.
  - Response: next cycle `line_start`, `busy` and `edge_idx` are 0, and all vertices read 0; no `frame_done`; a new `go` restarts at edge 0.
- Back-to-back frames:
  - Stimulus: `go` held high.
  - Response: the second frame's LOAD follows IDLE by 1 cycle after `frame_done`; 24 edges total.
- Degenerate edges:
  - Stimulus: all vertices = (5,5).
  - Response with `CUBE_SKIP_DEGENERATE_EN`: 0 `line_start` and `frame_done` within 30 cycles of `go`.
  - Response without it: 12 `line_start` assertions.

Source files
------------

// File: rtl/cube_pkg.sv
// Shared constants, FSM state type and the fixed 12-edge wireframe table for the cube
// edge sequencer.
package cube_pkg;

  localparam int unsigned X_W    = 11;
  localparam int unsigned Y_W    = 10;
  localparam int unsigned N_VERT = 8;
  localparam int unsigned N_EDGE = 12;
  localparam int unsigned VIDX_W = 3;
  localparam int unsigned EIDX_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWait,
    StRelease
  } state_e;

  typedef struct packed {
    logic [VIDX_W-1:0] a;
    logic [VIDX_W-1:0] b;
  } edge_t;

  // Vertex index bit0/1/2 = x/y/z side; edges 0-3 run along x, 4-7 along y, 8-11 along z.
  localparam edge_t EdgeTable [N_EDGE] = '{
    '{3'd0, 3'd1}, '{3'd2, 3'd3}, '{3'd4, 3'd5}, '{3'd6, 3'd7},
    '{3'd0, 3'd2}, '{3'd1, 3'd3}, '{3'd4, 3'd6}, '{3'd5, 3'd7},
    '{3'd0, 3'd4}, '{3'd1, 3'd5}, '{3'd2, 3'd6}, '{3'd3, 3'd7}
  };

  function automatic edge_t edge_of(logic [EIDX_W-1:0] idx);
    edge_t e;
    e = '0;
    if (idx < EIDX_W'(N_EDGE)) begin
      e = EdgeTable[idx];
    end
    return e;
  endfunction

endpackage

// File: rtl/cube_edge_sequencer_if.sv
// Host, vertex-load and drawer handshake bundle of the cube edge sequencer.
// master = sequencer side, slave = host/drawer side.
interface cube_edge_sequencer_if #(
  parameter int unsigned X_W = cube_pkg::X_W,
  parameter int unsigned Y_W = cube_pkg::Y_W
);

  logic                        vert_we;
  logic [cube_pkg::VIDX_W-1:0] vert_addr;
  logic [X_W-1:0]              vert_x;
  logic [Y_W-1:0]              vert_y;
  logic                        go;
  logic                        busy;
  logic                        frame_done;
  logic [cube_pkg::EIDX_W-1:0] edge_idx;
  logic                        line_start;
  logic [X_W-1:0]              line_x0;
  logic [X_W-1:0]              line_x1;
  logic [Y_W-1:0]              line_y0;
  logic [Y_W-1:0]              line_y1;
  logic                        line_done;

  modport master (
    input  vert_we, vert_addr, vert_x, vert_y, go, line_done,
    output busy, frame_done, edge_idx, line_start, line_x0, line_x1, line_y0, line_y1
  );

  modport slave (
    output vert_we, vert_addr, vert_x, vert_y, go, line_done,
    input  busy, frame_done, edge_idx, line_start, line_x0, line_x1, line_y0, line_y1
  );

endinterface

// File: rtl/cube_vertex_regs.sv
// Eight-entry vertex store (x,y per entry) with one gated write port and two
// combinational read ports for the two ends of the current edge.
module cube_vertex_regs #(
  parameter int unsigned X_W = cube_pkg::X_W,
  parameter int unsigned Y_W = cube_pkg::Y_W
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        we_i,
  input  logic [cube_pkg::VIDX_W-1:0] waddr_i,
  input  logic [X_W-1:0]              wx_i,
  input  logic [Y_W-1:0]              wy_i,
  input  logic [cube_pkg::VIDX_W-1:0] raddr_a_i,
  output logic [X_W-1:0]              rx_a_o,
  output logic [Y_W-1:0]              ry_a_o,
  input  logic [cube_pkg::VIDX_W-1:0] raddr_b_i,
  output logic [X_W-1:0]              rx_b_o,
  output logic [Y_W-1:0]              ry_b_o
);
  import cube_pkg::*;

  logic [X_W+Y_W-1:0] mem_q [N_VERT];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(N_VERT); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= {wx_i, wy_i};
    end
  end

  assign {rx_a_o, ry_a_o} = mem_q[raddr_a_i];
  assign {rx_b_o, ry_b_o} = mem_q[raddr_b_i];

endmodule

// File: rtl/cube_edge_sequencer.sv
// Walks the 12 cube edges on each go, handing endpoints to a line drawer via start/done.
// Optional CUBE_SKIP_DEGENERATE_EN: zero-length edges are skipped instead of issued.
module cube_edge_sequencer #(
  parameter int unsigned X_W = cube_pkg::X_W,
  parameter int unsigned Y_W = cube_pkg::Y_W
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  cube_edge_sequencer_if.master bus
);
  import cube_pkg::*;

  state_e              state_q, state_d;
  logic [EIDX_W-1:0]   edge_q, edge_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic                start_q, start_d;
  logic [X_W-1:0]      x0_q, x0_d, x1_q, x1_d;
  logic [Y_W-1:0]      y0_q, y0_d, y1_q, y1_d;

  logic [X_W-1:0]      rx_a, rx_b;
  logic [Y_W-1:0]      ry_a, ry_b;
  edge_t               cur_edge;
  logic                advance;
  logic                last_edge;

  assign cur_edge  = edge_of(edge_q);
  assign last_edge = (edge_q == EIDX_W'(N_EDGE - 1));

  // Writes are frozen while busy so a frame always renders one consistent vertex set.
  cube_vertex_regs #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_vertex_regs (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .we_i      (bus.vert_we & ~busy_q),
    .waddr_i   (bus.vert_addr),
    .wx_i      (bus.vert_x),
    .wy_i      (bus.vert_y),
    .raddr_a_i (cur_edge.a),
    .rx_a_o    (rx_a),
    .ry_a_o    (ry_a),
    .raddr_b_i (cur_edge.b),
    .rx_b_o    (rx_b),
    .ry_b_o    (ry_b)
  );

  always_comb begin
    state_d      = state_q;
    edge_d       = edge_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    start_d      = start_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    advance      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.go) begin
          edge_d  = '0;
          busy_d  = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        x0_d = rx_a;
        y0_d = ry_a;
        x1_d = rx_b;
        y1_d = ry_b;
`ifdef CUBE_SKIP_DEGENERATE_EN
        if ((rx_a == rx_b) && (ry_a == ry_b)) begin
          advance = 1'b1;
        end else begin
          start_d = 1'b1;
          state_d = StWait;
        end
`else
        start_d = 1'b1;
        state_d = StWait;
`endif
      end
      StWait: begin
        if (bus.line_done) begin
          start_d = 1'b0;
          state_d = StRelease;
        end
      end
      StRelease: begin
        // A drawer may hold done high; only move on once it has dropped.
        if (!bus.line_done) begin
          advance = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (advance) begin
      if (last_edge) begin
        busy_d       = 1'b0;
        frame_done_d = 1'b1;
        state_d      = StIdle;
      end else begin
        edge_d  = edge_q + EIDX_W'(1);
        state_d = StLoad;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      edge_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      start_q      <= 1'b0;
      x0_q         <= '0;
      y0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
    end else begin
      state_q      <= state_d;
      edge_q       <= edge_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      start_q      <= start_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.edge_idx   = edge_q;
  assign bus.line_start = start_q;
  assign bus.line_x0    = x0_q;
  assign bus.line_y0    = y0_q;
  assign bus.line_x1    = x1_q;
  assign bus.line_y1    = y1_q;

endmodule

// File: tb/tb_cube_edge_sequencer.sv
// Self-checking bench for cube_edge_sequencer: stub drawer, edge monitor and a
// geometric reference model of the cube edges.
module tb_cube_edge_sequencer;
  import cube_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cube_edge_sequencer_if bus ();

  cube_edge_sequencer #(
    .X_W (11),
    .Y_W (10)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  typedef struct {
    int idx;
    int x0;
    int y0;
    int x1;
    int y1;
  } line_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  line_t seen[$];
  line_t exp_q[$];
  int    mx[8];
  int    my[8];
  int    fd_cnt = 0;
  int    fd0 = 0;
  int    drop_delay = 1;
  bit    sticky_mode = 1'b0;
  int    last_idx = 0;
  int    low_gap = 0;
  bit    prev_start = 1'b0;
  int    s_cnt = 0;
  int    h_cnt = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drawer stub: done rises 5 cycles into start, drops drop_delay cycles after start falls.
  initial begin
    bus.line_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.line_start) begin
        h_cnt = 0;
        s_cnt++;
        if (s_cnt >= 5) bus.line_done = 1'b1;
      end else begin
        s_cnt = 0;
        if (bus.line_done) begin
          h_cnt++;
          if (h_cnt >= drop_delay) begin
            bus.line_done = 1'b0;
            h_cnt = 0;
          end
        end
      end
    end
  end

  // Monitor: records every issued line and counts frame_done pulses.
  initial begin
    forever begin
      line_t r;
      @(posedge clk);
      #1;
      if (bus.frame_done) fd_cnt++;
      if (bus.line_start && !prev_start) begin
        if (sticky_mode && bus.edge_idx != 0) check_eq("sticky_gap_ge20", int'(low_gap >= 20), 1);
        r.idx = int'(bus.edge_idx);
        r.x0  = int'(bus.line_x0);
        r.y0  = int'(bus.line_y0);
        r.x1  = int'(bus.line_x1);
        r.y1  = int'(bus.line_y1);
        seen.push_back(r);
        last_idx = r.idx;
      end
      if (sticky_mode && !bus.line_start && bus.line_done && bus.busy)
        check_eq("sticky_hold_idx", int'(bus.edge_idx), last_idx);
      low_gap    = bus.line_start ? 0 : low_gap + 1;
      prev_start = bus.line_start;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Cube geometry: edges 0-3 join vertices differing in bit0, 4-7 in bit1, 8-11 in bit2.
  task automatic ends_of(input int e, output int a, output int b);
    int k;
    if (e < 4) begin
      a = 2 * e;
      b = a + 1;
    end else if (e < 8) begin
      k = e - 4;
      a = (k / 2) * 4 + (k % 2);
      b = a + 2;
    end else begin
      a = e - 8;
      b = a + 4;
    end
  endtask

  task automatic build_expect();
    int    a, b;
    line_t r;
    for (int e = 0; e < 12; e++) begin
      ends_of(e, a, b);
`ifdef CUBE_SKIP_DEGENERATE_EN
      if (mx[a] == mx[b] && my[a] == my[b]) continue;
`endif
      r.idx = e;
      r.x0  = mx[a];
      r.y0  = my[a];
      r.x1  = mx[b];
      r.y1  = my[b];
      exp_q.push_back(r);
    end
  endtask

  task automatic compare_lines(input string tag);
    int n;
    check_eq({tag, "_count"}, seen.size(), exp_q.size());
    n = (seen.size() < exp_q.size()) ? seen.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_e%0d_idx", tag, i), seen[i].idx, exp_q[i].idx);
      check_eq($sformatf("%s_e%0d_x0", tag, i), seen[i].x0, exp_q[i].x0);
      check_eq($sformatf("%s_e%0d_y0", tag, i), seen[i].y0, exp_q[i].y0);
      check_eq($sformatf("%s_e%0d_x1", tag, i), seen[i].x1, exp_q[i].x1);
      check_eq($sformatf("%s_e%0d_y1", tag, i), seen[i].y1, exp_q[i].y1);
    end
  endtask

  task automatic write_vtx(input int a, input int x, input int y, input bit model);
    @(negedge clk);
    bus.vert_we   = 1'b1;
    bus.vert_addr = 3'(a);
    bus.vert_x    = 11'(x);
    bus.vert_y    = 10'(y);
    @(negedge clk);
    bus.vert_we = 1'b0;
    if (model) begin
      mx[a] = x;
      my[a] = y;
    end
  endtask

  task automatic load_spec_cube();
    for (int i = 0; i < 8; i++)
      write_vtx(i, 100 + 200 * (i & 1) + 60 * ((i >> 2) & 1),
                50 + 200 * ((i >> 1) & 1) + 40 * ((i >> 2) & 1), 1'b1);
  endtask

  task automatic start_frame();
    seen.delete();
    exp_q.delete();
    build_expect();
    fd0 = fd_cnt;
    @(negedge clk);
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
  endtask

  task automatic finish_frame(input string tag, output int cycles);
    cycles = 1;
    while (fd_cnt == fd0 && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
    repeat (3) @(negedge clk);
    check_eq({tag, "_frame_done_once"}, fd_cnt - fd0, 1);
    check_eq({tag, "_busy_after"}, int'(bus.busy), 0);
    compare_lines(tag);
  endtask

  task automatic wait_edge(input int e, input bit need_start);
    int c = 0;
    while (!(int'(bus.edge_idx) == e && (!need_start || bus.line_start)) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check_eq($sformatf("reach_edge%0d", e), int'(bus.edge_idx), e);
  endtask

  int cyc;

  initial begin
    reset         = 1'b1;
    bus.vert_we   = 1'b0;
    bus.vert_addr = '0;
    bus.vert_x    = '0;
    bus.vert_y    = '0;
    bus.go        = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mx[i] = 0;
      my[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_line_start", int'(bus.line_start), 0);
    check_eq("rst_busy", int'(bus.busy), 0);
    check_eq("rst_edge_idx", int'(bus.edge_idx), 0);
    check_eq("rst_frame_done", int'(bus.frame_done), 0);
    check_eq("rst_x0", int'(bus.line_x0), 0);
    check_eq("rst_y1", int'(bus.line_y1), 0);
    reset = 1'b0;

    // Basic frame with the reference cube.
    load_spec_cube();
    start_frame();
    finish_frame("basic", cyc);
    if (seen.size() == 12) begin
      check_eq("basic_e0_x0", seen[0].x0, 100);
      check_eq("basic_e0_x1", seen[0].x1, 300);
      check_eq("basic_e0_y1", seen[0].y1, 50);
      check_eq("basic_e4_y0", seen[4].y0, 50);
      check_eq("basic_e4_x1", seen[4].x1, 100);
      check_eq("basic_e4_y1", seen[4].y1, 250);
      check_eq("basic_e11_x0", seen[11].x0, 300);
      check_eq("basic_e11_y0", seen[11].y0, 250);
      check_eq("basic_e11_x1", seen[11].x1, 360);
      check_eq("basic_e11_y1", seen[11].y1, 290);
    end

    // go and vertex writes during a frame are ignored.
    start_frame();
    wait_edge(3, 1'b0);
    write_vtx(7, 0, 0, 1'b0);
    bus.go = 1'b1;
    write_vtx(int'($urandom_range(7)), int'($urandom_range(2047)), int'($urandom_range(1023)), 1'b0);
    bus.go = 1'b0;
    finish_frame("ignored", cyc);
    if (seen.size() == 12) check_eq("ignored_e11_x1", seen[11].x1, 360);
    start_frame();
    finish_frame("v7_kept", cyc);
    if (seen.size() == 12) check_eq("v7_kept_e11_y1", seen[11].y1, 290);

    // Random vertex sets.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++)
        write_vtx(i, int'($urandom_range(2047)), int'($urandom_range(1023)), 1'b1);
      start_frame();
      finish_frame($sformatf("rand%0d", f), cyc);
    end

    // Sticky done from the drawer.
    load_spec_cube();
    drop_delay  = 20;
    sticky_mode = 1'b1;
    start_frame();
    finish_frame("sticky", cyc);
    sticky_mode = 1'b0;
    drop_delay  = 1;
    repeat (25) @(negedge clk);

    // Reset during WAIT of edge 6.
    start_frame();
    wait_edge(6, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #2;
    check_eq("midrst_line_start", int'(bus.line_start), 0);
    check_eq("midrst_busy", int'(bus.busy), 0);
    check_eq("midrst_edge_idx", int'(bus.edge_idx), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mx[i] = 0;
      my[i] = 0;
    end
    repeat (6) @(negedge clk);
    check_eq("midrst_no_frame_done", fd_cnt - fd0, 0);
    start_frame();
    finish_frame("after_rst", cyc);

    // Back-to-back frames with go held high.
    load_spec_cube();
    seen.delete();
    exp_q.delete();
    build_expect();
    build_expect();
    fd0 = fd_cnt;
    @(negedge clk);
    bus.go = 1'b1;
    cyc = 0;
    while (fd_cnt == fd0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("b2b_fd_seen", int'(bus.frame_done), 1);
    check_eq("b2b_idle_busy", int'(bus.busy), 0);
    @(posedge clk);
    #2;
    check_eq("b2b_load_busy", int'(bus.busy), 1);
    check_eq("b2b_load_start", int'(bus.line_start), 0);
    @(posedge clk);
    #2;
    check_eq("b2b_second_start", int'(bus.line_start), 1);
    cyc = 0;
    while (fd_cnt < fd0 + 2 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    bus.go = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("b2b_frames", fd_cnt - fd0, 2);
    compare_lines("b2b");

    // Degenerate cube: every vertex at (5,5).
    for (int i = 0; i < 8; i++) write_vtx(i, 5, 5, 1'b1);
    start_frame();
    finish_frame("degen", cyc);
`ifdef CUBE_SKIP_DEGENERATE_EN
    check_eq("degen_fast", int'(cyc <= 30), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
